alu_ex_mem_stage: RTL and testbench

//  EX->MEM pipeline stage directly downstream of the combinational ALU. Captures alu_data with
//  its destination tag, writes in a zero flag, and presents it to the MEM/WB side over a

---
 rtl/alu_ex_mem_stage.sv | 169 ++++++++++++++++
 tb/tb_alu_ex_mem_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_mem_stage.sv
// alu_ex_mem_stage
//   EX->MEM pipeline register sitting directly behind the combinational ALU.
//   Captures the ALU result with its destination tag and a zero flag, and
//   presents it to MEM/WB over a valid/ready handshake.  A two-entry skid
//   buffer lets in_ready_o come straight from a flop, so there is no
//   combinational path from out_ready_i back into EX.  Supports a pipeline
//   flush and counts retired (taken) results.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   flush_i                drop all held and incoming results
//   in_valid_i/in_ready_o  EX-side handshake
//   alu_data_i, alu_op_i   ALU result and the opcode that produced it
//   rd_addr_i, rd_we_i     destination register index and write enable
//   out_valid_o/out_ready_i MEM-side handshake
//   out_data_o, out_rd_addr_o, out_rd_we_o, out_zero_o  registered result
//   retire_cnt_o           completed output handshakes, wraps
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no entry held, out_valid_o=0
// ST_ONE   | main entry valid, skid empty
// ST_FULL  | main and skid valid, in_ready_o=0
module alu_ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [3:0]        alu_op_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_we_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [REG_AW-1:0] out_rd_addr_o,
    output logic              out_rd_we_o,
    output logic              out_zero_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [REG_AW-1:0] r_main_rd;
    logic              r_main_we;
    logic              r_main_zero;
    logic [DATA_W-1:0] r_skid_data;
    logic [REG_AW-1:0] r_skid_rd;
    logic              r_skid_we;
    logic              r_skid_zero;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_accept;
    logic              w_take;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_cap_we;
    logic              w_cap_zero;

    assign w_accept = in_valid_i & r_in_ready;
    assign w_take   = r_out_valid & out_ready_i;

    // SLT/SLTU only produce a single meaningful bit; clear the rest so a
    // sloppy ALU upper half can never leak into writeback.  x0 is never written.
    always_comb begin
        w_cap_data = alu_data_i;
        if (alu_op_i == 4'b0010 || alu_op_i == 4'b0011) begin
            w_cap_data = {{(DATA_W-1){1'b0}}, alu_data_i[0]};
        end
        w_cap_we   = rd_we_i & (rd_addr_i != '0);
        w_cap_zero = (w_cap_data == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_main_data  <= '0;
            r_main_rd    <= '0;
            r_main_we    <= 1'b0;
            r_main_zero  <= 1'b1;
            r_skid_data  <= '0;
            r_skid_rd    <= '0;
            r_skid_we    <= 1'b0;
            r_skid_zero  <= 1'b1;
            r_retire_cnt <= '0;
        end else begin
            // A take coinciding with a flush still completed on the MEM side.
            if (w_take) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end

            if (flush_i) begin
                r_state     <= ST_EMPTY;
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_main_data <= w_cap_data;
                            r_main_rd   <= rd_addr_i;
                            r_main_we   <= w_cap_we;
                            r_main_zero <= w_cap_zero;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_accept && w_take) begin
                            r_main_data <= w_cap_data;
                            r_main_rd   <= rd_addr_i;
                            r_main_we   <= w_cap_we;
                            r_main_zero <= w_cap_zero;
                        end else if (w_accept) begin
                            // Main is still presented and must hold; park the new one.
                            r_skid_data <= w_cap_data;
                            r_skid_rd   <= rd_addr_i;
                            r_skid_we   <= w_cap_we;
                            r_skid_zero <= w_cap_zero;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_FULL;
                        end else if (w_take) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (w_take) begin
                            r_main_data <= r_skid_data;
                            r_main_rd   <= r_skid_rd;
                            r_main_we   <= r_skid_we;
                            r_main_zero <= r_skid_zero;
                            r_in_ready  <= 1'b1;
                            r_state     <= ST_ONE;
                        end
                    end
                    default: begin
                        r_state     <= ST_EMPTY;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready_o    = r_in_ready;
    assign out_valid_o   = r_out_valid;
    assign out_data_o    = r_main_data;
    assign out_rd_addr_o = r_main_rd;
    assign out_rd_we_o   = r_main_we;
    assign out_zero_o    = r_main_zero;
    assign retire_cnt_o  = r_retire_cnt;

endmodule

// File: tb/tb_alu_ex_mem_stage.sv
// Testbench for alu_ex_mem_stage: directed scenarios plus a randomised run
// against a queue model.  Inputs change on the falling edge, outputs are
// checked on the falling edge before new stimulus is applied.
module tb_alu_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_data;
    logic [3:0]    alu_op;
    logic [AW-1:0] rd_addr;
    logic          rd_we;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_rd;
    logic          out_we;
    logic          out_zero;
    logic [CW-1:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] rd;
        logic          we;
        logic          z;
    } ent_t;

    ent_t          q[$];
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    alu_ex_mem_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .alu_data_i   (alu_data),
        .alu_op_i     (alu_op),
        .rd_addr_i    (rd_addr),
        .rd_we_i      (rd_we),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_rd_addr_o(out_rd),
        .out_rd_we_o  (out_we),
        .out_zero_o   (out_zero),
        .retire_cnt_o (retire_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1);
    end

    task automatic drive_in(input logic v, input logic [DW-1:0] d, input logic [3:0] op,
                            input logic [AW-1:0] rd, input logic we);
        in_valid = v;
        alu_data = d;
        alu_op   = op;
        rd_addr  = rd;
        rd_we    = we;
    endtask

    // Expected stored entry, written from the opcode table directly.
    function automatic ent_t expect_entry(input logic [DW-1:0] d, input logic [3:0] op,
                                          input logic [AW-1:0] rd, input logic we);
        ent_t e;
        e.d  = (op == 4'd2 || op == 4'd3) ? DW'(d[0]) : d;
        e.rd = rd;
        e.we = we && (rd != 0);
        e.z  = (e.d == 0);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
        #12;
        checks++;
        if ({out_valid, in_ready, out_we, out_zero} !== 4'b0101) begin
            errors++;
            $display("FAIL reset_flags: got v/rdy/we/z=%b expected 0101",
                     {out_valid, in_ready, out_we, out_zero});
        end
        checks++;
        if ({out_data, out_rd, retire_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values: got data=%h rd=%0d cnt=%0d expected all 0",
                     out_data, out_rd, retire_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_pass();
        @(negedge clk);
        out_ready = 1'b1;
        drive_in(1'b1, 32'h0000_0005, 4'd0, 5'd3, 1'b1);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_rd, out_we, out_zero} !== {1'b1, 32'd5, 5'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_pass: got v=%b d=%h rd=%0d we=%b z=%b expected v=1 d=5 rd=3 we=1 z=0",
                     out_valid, out_data, out_rd, out_we, out_zero);
        end
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid, retire_cnt} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL single_retire: got v=%b cnt=%0d expected v=0 cnt=1", out_valid, retire_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_in(1'b1, 32'hAAAA_0001, 4'd0, 5'd1, 1'b1);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 32'hAAAA_0001}) begin
            errors++;
            $display("FAIL bp_after_A: got rdy=%b v=%b d=%h expected 1 1 aaaa0001", in_ready, out_valid, out_data);
        end
        drive_in(1'b1, 32'hBBBB_0002, 4'd0, 5'd2, 1'b1);
        @(negedge clk);
        checks++;
        if ({in_ready, out_data} !== {1'b0, 32'hAAAA_0001}) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b d=%h expected 0 aaaa0001", in_ready, out_data);
        end
        drive_in(1'b1, 32'hCCCC_0003, 4'd0, 5'd3, 1'b1);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_rd} !== {1'b0, 1'b1, 32'hAAAA_0001, 5'd1}) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b v=%b d=%h rd=%0d expected 0 1 aaaa0001 1",
                     in_ready, out_valid, out_data, out_rd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_data, out_rd} !== {1'b1, 32'hBBBB_0002, 5'd2}) begin
            errors++;
            $display("FAIL bp_second: got rdy=%b d=%h rd=%0d expected 1 bbbb0002 2", in_ready, out_data, out_rd);
        end
        @(negedge clk);
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_rd} !== {1'b1, 32'hCCCC_0003, 5'd3}) begin
            errors++;
            $display("FAIL bp_third: got v=%b d=%h rd=%0d expected 1 cccc0003 3", out_valid, out_data, out_rd);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, retire_cnt} !== {1'b0, 4'd4}) begin
            errors++;
            $display("FAIL bp_drain: got v=%b cnt=%0d expected v=0 cnt=4", out_valid, retire_cnt);
        end
    endtask

    task automatic test_sanitise();
        logic [3:0]    ops[4] = '{4'd3, 4'd0, 4'd2, 4'hC};
        logic [DW-1:0] din[4] = '{32'hFFFF_FFFF, 32'h0, 32'h2, 32'h8000_0002};
        logic [AW-1:0] rds[4] = '{5'd0, 5'd7, 5'd4, 5'd9};
        logic          wes[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] exd[4] = '{32'h1, 32'h0, 32'h0, 32'h8000_0002};
        logic          exw[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic          exz[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                checks++;
                if ({out_valid, out_data, out_rd, out_we, out_zero} !==
                    {1'b1, exd[i-1], rds[i-1], exw[i-1], exz[i-1]}) begin
                    errors++;
                    $display("FAIL sanitise_%0d: got v=%b d=%h rd=%0d we=%b z=%b expected v=1 d=%h rd=%0d we=%b z=%b",
                             i-1, out_valid, out_data, out_rd, out_we, out_zero,
                             exd[i-1], rds[i-1], exw[i-1], exz[i-1]);
                end
            end
            if (i < 4) drive_in(1'b1, din[i], ops[i], rds[i], wes[i]);
            else       drive_in(1'b0, '0, 4'd0, '0, 1'b0);
            @(negedge clk);
        end
        checks++;
        if ({out_valid, retire_cnt} !== {1'b0, 4'd8}) begin
            errors++;
            $display("FAIL sanitise_drain: got v=%b cnt=%0d expected v=0 cnt=8", out_valid, retire_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_in(1'b1, 32'h1111_0001, 4'd0, 5'd1, 1'b1);
        @(negedge clk);
        drive_in(1'b1, 32'h2222_0002, 4'd0, 5'd2, 1'b1);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL flush_prefull: got rdy=%b v=%b expected 0 1", in_ready, out_valid);
        end
        flush = 1'b1;
        drive_in(1'b1, 32'hDDDD_0004, 4'd0, 5'd4, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_empty: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        drive_in(1'b1, 32'hEEEE_0005, 4'd0, 5'd5, 1'b1);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_rd} !== {1'b1, 32'hEEEE_0005, 5'd5}) begin
            errors++;
            $display("FAIL flush_next: got v=%b d=%h rd=%0d expected 1 eeee0005 5", out_valid, out_data, out_rd);
        end
        // Flush together with a take: the take still retires.
        flush = 1'b1;
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({out_valid, in_ready, retire_cnt} !== {1'b0, 1'b1, 4'd9}) begin
            errors++;
            $display("FAIL flush_take: got v=%b rdy=%b cnt=%0d expected 0 1 9", out_valid, in_ready, retire_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        #1;
        checks++;
        if (retire_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_reset: got cnt=%0d expected 0", retire_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) begin
                checks++;
                if ({out_valid, out_data} !== {1'b1, DW'(i-1)}) begin
                    errors++;
                    $display("FAIL wrap_stream_%0d: got v=%b d=%h expected 1 %h", i-1, out_valid, out_data, DW'(i-1));
                end
            end
            drive_in(1'b1, DW'(i), 4'd0, 5'd1, 1'b1);
            @(negedge clk);
        end
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid, retire_cnt} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL wrap_count: got v=%b cnt=%0d expected v=0 cnt=1", out_valid, retire_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_in(1'b1, 32'h0000_1234, 4'd0, 5'd5, 1'b1);
        @(negedge clk);
        drive_in(1'b1, 32'h0000_5678, 4'd0, 5'd6, 1'b1);
        @(negedge clk);
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_data, out_rd, out_we, out_zero, retire_cnt} !==
            {1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b rdy=%b d=%h rd=%0d we=%b z=%b cnt=%0d expected 0 1 0 0 0 1 0",
                     out_valid, in_ready, out_data, out_rd, out_we, out_zero, retire_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic          v, f, r, we;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        logic          rdy_before;
        ent_t          e;
        bit            take, acc;
        q.delete();
        m_cnt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, retire_cnt} !== {q.size() > 0, q.size() < 2, m_cnt}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got v=%b rdy=%b cnt=%0d expected v=%b rdy=%b cnt=%0d",
                         cyc, out_valid, in_ready, retire_cnt, q.size() > 0, q.size() < 2, m_cnt);
            end
            if (q.size() > 0) begin
                checks++;
                if ({out_data, out_rd, out_we, out_zero} !== {q[0].d, q[0].rd, q[0].we, q[0].z}) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d: got d=%h rd=%0d we=%b z=%b expected d=%h rd=%0d we=%b z=%b",
                             cyc, out_data, out_rd, out_we, out_zero, q[0].d, q[0].rd, q[0].we, q[0].z);
                end
            end
            // Wiggle out_ready between edges; in_ready must not follow it.
            rdy_before = in_ready;
            out_ready = ~out_ready;
            #1;
            checks++;
            if (in_ready !== rdy_before) begin
                errors++;
                $display("FAIL rand_ready_comb cyc %0d: got rdy=%b expected %b", cyc, in_ready, rdy_before);
            end
            v  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 2) != 0);
            op = 4'($urandom_range(0, 15));
            rd = AW'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            out_ready = r;
            flush = f;
            drive_in(v, d, op, rd, we);
            take = (q.size() > 0) && r;
            acc  = v && (q.size() < 2);
            if (take) m_cnt = m_cnt + 1'b1;
            if (f) begin
                q.delete();
            end else begin
                if (take) void'(q.pop_front());
                if (acc) begin
                    e = expect_entry(d, op, rd, we);
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
        flush = 1'b0;
        drive_in(1'b0, '0, 4'd0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_backpressure();
        test_sanitise();
        test_flush();
        test_counter_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
